// File: rtl/fp_hs_pkg.sv
// Shared definitions for the stb/ack floating-point core front ends.
package fp_hs_pkg;

    localparam int FP_W = 32;

    // Default quiet NaN returned when a core never answers.
    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC00000;

    // Issuer FSM encoding.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_WAIT_Z = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    typedef logic [1:0] fsm_state_t;

endpackage

// File: rtl/hs_watchdog.sv
// Clear/enable watchdog counter. Flags expiry once TIMEOUT-1 enabled cycles
// have elapsed since the last clear, so the owner reacts on the TIMEOUT-th edge.
module hs_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    // Count enabled cycles, parking at LAST so the flag cannot wrap away.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expired = i_en && (r_cnt == LAST);

endmodule

// File: rtl/fp_op_issuer.sv
// Initiator front end for an stb/ack floating-point core: valid/ready command
// in, operand strobe out, result strobe in, tagged response out, with a
// watchdog that turns a hung core into an error response.
module fp_op_issuer
    import fp_hs_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [FP_W-1:0]  i_cmd_a,
    input  logic [FP_W-1:0]  i_cmd_b,
    input  logic [TAG_W-1:0] i_cmd_tag,
    output logic [FP_W-1:0]  o_core_a,
    output logic [FP_W-1:0]  o_core_b,
    output logic             o_core_a_stb,
    output logic             o_core_b_stb,
    input  logic             i_core_a_ack,
    input  logic             i_core_b_ack,
    input  logic [FP_W-1:0]  i_core_z,
    input  logic             i_core_z_stb,
    output logic             o_core_z_ack,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [FP_W-1:0]  o_rsp_z,
    output logic [TAG_W-1:0] o_rsp_tag,
    output logic             o_rsp_err,
    output logic             o_hung,
    output logic [31:0]      o_op_count
);

    fsm_state_t       r_state;
    logic [FP_W-1:0]  r_a;
    logic [FP_W-1:0]  r_b;
    logic [TAG_W-1:0] r_tag;
    logic [FP_W-1:0]  r_rsp_z;
    logic             r_rsp_err;
    logic             r_hung;
    logic [31:0]      r_op_count;

    logic w_cmd_hs;
    logic w_result_hs;
    logic w_wd_en;
    logic w_expired;
    logic w_timeout;

    // The b operand travels with a, so the core's b ack carries no information.
    logic w_unused_b_ack;
    assign w_unused_b_ack = i_core_b_ack;

    // Handshakes qualified by state so no input reaches an output combinationally.
    assign w_cmd_hs    = (r_state == ST_IDLE) && i_cmd_valid;
    assign w_result_hs = (r_state == ST_WAIT_Z) && i_core_z_stb;
    assign w_wd_en     = (r_state == ST_ISSUE) || (r_state == ST_WAIT_Z);
    // A result on the expiry edge wins over the timeout.
    assign w_timeout   = w_expired && !w_result_hs;

    hs_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (w_cmd_hs),
        .i_en      (w_wd_en),
        .o_expired (w_expired)
    );

    // Sequencing: one operation in flight, IDLE -> ISSUE -> WAIT_Z -> RESP.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (i_cmd_valid)  r_state <= ST_ISSUE;
                ST_ISSUE:  if (w_timeout)    r_state <= ST_RESP;
                           else if (i_core_a_ack) r_state <= ST_WAIT_Z;
                ST_WAIT_Z: if (w_result_hs || w_timeout) r_state <= ST_RESP;
                ST_RESP:   if (i_rsp_ready)  r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    // Operands and tag only move on a command handshake, keeping them stable
    // for a core that captures one cycle after the strobe handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_tag <= '0;
        end else if (w_cmd_hs) begin
            r_a   <= i_cmd_a;
            r_b   <= i_cmd_b;
            r_tag <= i_cmd_tag;
        end
    end

    // Response payload: the core result, or a quiet NaN with err on timeout.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_z   <= '0;
            r_rsp_err <= 1'b0;
        end else if (w_result_hs) begin
            r_rsp_z   <= i_core_z;
            r_rsp_err <= 1'b0;
        end else if (w_timeout) begin
            r_rsp_z   <= FP_QNAN;
            r_rsp_err <= 1'b1;
        end
    end

    // Completion counter and sticky hung flag; only rst clears hung.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op_count <= '0;
            r_hung     <= 1'b0;
        end else begin
            if (w_result_hs) r_op_count <= r_op_count + 32'd1;
            if (w_timeout)   r_hung     <= 1'b1;
        end
    end

    // Handshake controls decoded from state alone. Dropping z_ack in RESP
    // stops a core that holds its strobe an extra cycle from counting twice,
    // and keeping it high in IDLE drains stray results.
    assign o_cmd_ready  = (r_state == ST_IDLE);
    assign o_core_a_stb = (r_state == ST_ISSUE);
    assign o_core_b_stb = (r_state == ST_ISSUE);
    assign o_core_z_ack = (r_state == ST_IDLE) || (r_state == ST_WAIT_Z);
    assign o_rsp_valid  = (r_state == ST_RESP);

    assign o_core_a   = r_a;
    assign o_core_b   = r_b;
    assign o_rsp_z    = r_rsp_z;
    assign o_rsp_tag  = r_tag;
    assign o_rsp_err  = r_rsp_err;
    assign o_hung     = r_hung;
    assign o_op_count = r_op_count;

endmodule

// File: tb/tb_fp_op_issuer.sv
// Directed bench for fp_op_issuer; the bench plays the role of the core.
module tb_fp_op_issuer;

    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [31:0]      cmd_a = '0;
    logic [31:0]      cmd_b = '0;
    logic [TAG_W-1:0] cmd_tag = '0;
    logic [31:0]      core_a, core_b;
    logic             core_a_stb, core_b_stb;
    logic             core_a_ack = 1'b0;
    logic             core_b_ack = 1'b0;
    logic [31:0]      core_z = '0;
    logic             core_z_stb = 1'b0;
    logic             core_z_ack;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [31:0]      rsp_z;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic             hung;
    logic [31:0]      op_count;

    int vec = 0;
    int err = 0;
    int xfer = 0;

    fp_op_issuer #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_a      (cmd_a),
        .i_cmd_b      (cmd_b),
        .i_cmd_tag    (cmd_tag),
        .o_core_a     (core_a),
        .o_core_b     (core_b),
        .o_core_a_stb (core_a_stb),
        .o_core_b_stb (core_b_stb),
        .i_core_a_ack (core_a_ack),
        .i_core_b_ack (core_b_ack),
        .i_core_z     (core_z),
        .i_core_z_stb (core_z_stb),
        .o_core_z_ack (core_z_ack),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_z      (rsp_z),
        .o_rsp_tag    (rsp_tag),
        .o_rsp_err    (rsp_err),
        .o_hung       (hung),
        .o_op_count   (op_count)
    );

    always #5 clk = ~clk;

    // Operand transfers as seen by the core.
    always @(posedge clk) if (core_a_stb && core_a_ack) xfer++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // flags = {cmd_ready, a_stb, b_stb, z_ack, rsp_valid, rsp_err, hung}
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vec++; if ({cmd_ready, core_a_stb, core_b_stb, core_z_ack, rsp_valid, rsp_err, hung} !== 7'b1001000) begin
            err++; $display("FAIL reset_flags got %b exp 1001000", {cmd_ready, core_a_stb, core_b_stb, core_z_ack, rsp_valid, rsp_err, hung}); end
        vec++; if (op_count !== 32'd0) begin err++; $display("FAIL reset_op_count got %0d exp 0", op_count); end
        vec++; if ({rsp_z, rsp_tag, core_a, core_b} !== '0) begin
            err++; $display("FAIL reset_data got %h %h %h %h exp zeros", rsp_z, rsp_tag, core_a, core_b); end
    endtask

    // 3.0 * 2.0 = 6.0, core acks immediately and answers one cycle later.
    task automatic test_basic();
        cmd_valid = 1'b1; cmd_a = 32'h40400000; cmd_b = 32'h40000000; cmd_tag = 4'd5; core_a_ack = 1'b1;
        tick();
        cmd_valid = 1'b0;
        vec++; if ({core_a_stb, core_b_stb, cmd_ready, core_z_ack} !== 4'b1100) begin
            err++; $display("FAIL basic_issue got %b exp 1100", {core_a_stb, core_b_stb, cmd_ready, core_z_ack}); end
        vec++; if ({core_a, core_b} !== {32'h40400000, 32'h40000000}) begin
            err++; $display("FAIL basic_operands got %h %h exp 40400000 40000000", core_a, core_b); end
        tick();
        vec++; if ({core_a_stb, core_z_ack, rsp_valid} !== 3'b010) begin
            err++; $display("FAIL basic_wait got %b exp 010", {core_a_stb, core_z_ack, rsp_valid}); end
        core_z = 32'h40C00000; core_z_stb = 1'b1;
        tick();
        core_z_stb = 1'b0; core_a_ack = 1'b0;
        vec++; if ({rsp_valid, rsp_err, core_z_ack, cmd_ready} !== 4'b1000) begin
            err++; $display("FAIL basic_resp_flags got %b exp 1000", {rsp_valid, rsp_err, core_z_ack, cmd_ready}); end
        vec++; if (rsp_z !== 32'h40C00000 || rsp_tag !== 4'd5) begin
            err++; $display("FAIL basic_rsp got %h tag %h exp 40c00000 tag 5", rsp_z, rsp_tag); end
        vec++; if (op_count !== 32'd1) begin err++; $display("FAIL basic_op_count got %0d exp 1", op_count); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        vec++; if ({rsp_valid, cmd_ready} !== 2'b01) begin
            err++; $display("FAIL basic_return_idle got %b exp 01", {rsp_valid, cmd_ready}); end
    endtask

    // 1.0 * -2.0 = -2.0 with the core refusing operands for 10 cycles.
    task automatic test_ack_stall();
        int x0;
        x0 = xfer;
        cmd_valid = 1'b1; cmd_a = 32'h3F800000; cmd_b = 32'hC0000000; cmd_tag = 4'd9; core_a_ack = 1'b0;
        tick();
        cmd_valid = 1'b0; cmd_a = 32'hFFFFFFFF; cmd_b = 32'hFFFFFFFF;
        for (int i = 0; i < 10; i++) begin
            vec++; if (core_a_stb !== 1'b1 || core_b_stb !== 1'b1 || core_a !== 32'h3F800000 || core_b !== 32'hC0000000) begin
                err++; $display("FAIL stall_hold[%0d] got stb %b a %h b %h exp 1 3f800000 c0000000", i, core_a_stb, core_a, core_b); end
            tick();
        end
        core_a_ack = 1'b1;
        vec++; if (core_a_stb !== 1'b1 || xfer - x0 !== 0) begin
            err++; $display("FAIL stall_pre_xfer got stb %b xfers %0d exp 1 0", core_a_stb, xfer - x0); end
        tick();
        vec++; if (core_a_stb !== 1'b0 || core_a !== 32'h3F800000) begin
            err++; $display("FAIL stall_post_xfer got stb %b a %h exp 0 3f800000", core_a_stb, core_a); end
        core_z = 32'hC0000000; core_z_stb = 1'b1;
        tick();
        core_z_stb = 1'b0; core_a_ack = 1'b0;
        vec++; if (xfer - x0 !== 1) begin err++; $display("FAIL stall_xfer_count got %0d exp 1", xfer - x0); end
        vec++; if (rsp_valid !== 1'b1 || rsp_z !== 32'hC0000000 || rsp_tag !== 4'd9 || rsp_err !== 1'b0 || op_count !== 32'd2) begin
            err++; $display("FAIL stall_rsp got v %b z %h tag %h err %b cnt %0d exp 1 c0000000 9 0 2", rsp_valid, rsp_z, rsp_tag, rsp_err, op_count); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // Response held under back-pressure while a new command waits.
    task automatic test_rsp_hold();
        cmd_valid = 1'b1; cmd_a = 32'h40000000; cmd_b = 32'h40400000; cmd_tag = 4'd2; core_a_ack = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        core_a_ack = 1'b0; core_z = 32'h40C00000; core_z_stb = 1'b1;
        tick();
        core_z_stb = 1'b0;
        cmd_valid = 1'b1; cmd_a = 32'h3F800000; cmd_b = 32'h3F800000; cmd_tag = 4'd7;
        for (int i = 0; i < 7; i++) begin
            vec++; if (rsp_valid !== 1'b1 || rsp_z !== 32'h40C00000 || rsp_tag !== 4'd2 || cmd_ready !== 1'b0) begin
                err++; $display("FAIL hold[%0d] got v %b z %h tag %h rdy %b exp 1 40c00000 2 0", i, rsp_valid, rsp_z, rsp_tag, cmd_ready); end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        vec++; if ({cmd_ready, rsp_valid, core_a_stb} !== 3'b100) begin
            err++; $display("FAIL hold_after_hs got %b exp 100", {cmd_ready, rsp_valid, core_a_stb}); end
        tick();
        cmd_valid = 1'b0;
        vec++; if (core_a_stb !== 1'b1 || core_a !== 32'h3F800000) begin
            err++; $display("FAIL hold_next_cmd got stb %b a %h exp 1 3f800000", core_a_stb, core_a); end
        core_a_ack = 1'b1;
        tick();
        core_a_ack = 1'b0; core_z = 32'h3F800000; core_z_stb = 1'b1;
        tick();
        core_z_stb = 1'b0;
        vec++; if (rsp_valid !== 1'b1 || rsp_z !== 32'h3F800000 || rsp_tag !== 4'd7 || op_count !== 32'd4) begin
            err++; $display("FAIL hold_second_rsp got v %b z %h tag %h cnt %0d exp 1 3f800000 7 4", rsp_valid, rsp_z, rsp_tag, op_count); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // Core takes operands but never answers.
    task automatic test_timeout();
        int cyc;
        cmd_valid = 1'b1; cmd_a = 32'h40400000; cmd_b = 32'h40400000; cmd_tag = 4'hC; core_a_ack = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        core_a_ack = 1'b0;
        cyc = 1;
        while (rsp_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        vec++; if (cyc !== TIMEOUT) begin err++; $display("FAIL timeout_latency got %0d exp %0d", cyc, TIMEOUT); end
        vec++; if (rsp_err !== 1'b1 || rsp_z !== 32'h7FC00000 || rsp_tag !== 4'hC || hung !== 1'b1 || op_count !== 32'd4) begin
            err++; $display("FAIL timeout_rsp got err %b z %h tag %h hung %b cnt %0d exp 1 7fc00000 c 1 4", rsp_err, rsp_z, rsp_tag, hung, op_count); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        vec++; if ({hung, rsp_valid, cmd_ready} !== 3'b101) begin
            err++; $display("FAIL timeout_sticky got %b exp 101", {hung, rsp_valid, cmd_ready}); end
    endtask

    // The hung core's late result shows up in IDLE and must vanish.
    task automatic test_late_drain();
        core_z = 32'h41100000; core_z_stb = 1'b1;
        vec++; if (core_z_ack !== 1'b1) begin err++; $display("FAIL drain_ack got %b exp 1", core_z_ack); end
        tick();
        core_z_stb = 1'b0;
        vec++; if (rsp_valid !== 1'b0 || op_count !== 32'd4 || hung !== 1'b1 || cmd_ready !== 1'b1) begin
            err++; $display("FAIL drain_state got v %b cnt %0d hung %b rdy %b exp 0 4 1 1", rsp_valid, op_count, hung, cmd_ready); end
        tick();
        vec++; if (rsp_valid !== 1'b0) begin err++; $display("FAIL drain_no_rsp got %b exp 0", rsp_valid); end
    endtask

    // Reset while waiting on the core, then a normal 2.0 * 2.0 = 4.0.
    task automatic test_rst_mid();
        cmd_valid = 1'b1; cmd_a = 32'h40000000; cmd_b = 32'h40000000; cmd_tag = 4'd3; core_a_ack = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        core_a_ack = 1'b0;
        vec++; if ({core_a_stb, core_z_ack, rsp_valid} !== 3'b010) begin
            err++; $display("FAIL rst_in_wait got %b exp 010", {core_a_stb, core_z_ack, rsp_valid}); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vec++; if ({cmd_ready, core_a_stb, core_b_stb, core_z_ack, rsp_valid, rsp_err, hung} !== 7'b1001000) begin
            err++; $display("FAIL rst_flags got %b exp 1001000", {cmd_ready, core_a_stb, core_b_stb, core_z_ack, rsp_valid, rsp_err, hung}); end
        vec++; if ({rsp_z, rsp_tag, core_a, core_b} !== '0 || op_count !== 32'd0) begin
            err++; $display("FAIL rst_data got z %h tag %h a %h b %h cnt %0d exp zeros", rsp_z, rsp_tag, core_a, core_b, op_count); end
        core_z = 32'h40800000; core_z_stb = 1'b1;
        tick();
        core_z_stb = 1'b0;
        vec++; if (rsp_valid !== 1'b0 || op_count !== 32'd0) begin
            err++; $display("FAIL rst_drain got v %b cnt %0d exp 0 0", rsp_valid, op_count); end
        cmd_valid = 1'b1; core_a_ack = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        core_a_ack = 1'b0; core_z = 32'h40800000; core_z_stb = 1'b1;
        tick();
        core_z_stb = 1'b0;
        vec++; if (rsp_valid !== 1'b1 || rsp_z !== 32'h40800000 || rsp_tag !== 4'd3 || rsp_err !== 1'b0 || op_count !== 32'd1) begin
            err++; $display("FAIL rst_next_cmd got v %b z %h tag %h err %b cnt %0d exp 1 40800000 3 0 1", rsp_valid, rsp_z, rsp_tag, rsp_err, op_count); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ack_stall();
        test_rsp_hold();
        test_timeout();
        test_late_drain();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/fp_op_issuer.md
# fp_op_issuer

Initiator-side front end for the stb/ack floating-point cores (multiplier and siblings). Accepts operand commands on a valid/ready port, drives the core's operand strobe, collects the core's result strobe and returns a tagged response. Adds a watchdog so a hung core produces an error response rather than a stalled bus.

## Interface
- TAG_W, 4: command/response tag width
- TIMEOUT, 1024: cycles allowed from entering ISSUE to result handshake; must be at least 2
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at an edge
- cmd_a, cmd_b  in  32  IEEE-754 single operands
- cmd_tag  in  TAG_W  returned unchanged with the response
- core_a, core_b  out  32  operands to the core
- core_a_stb, core_b_stb  out  1  operand strobe; b_stb always equals a_stb
- core_a_ack  in  1  core ready for operands
- core_b_ack  in  1  ignored; b transfers with a
- core_z  in  32  core result
- core_z_stb  in  1  core result valid
- core_z_ack  out  1  result accept
- rsp_valid  out  1  response held until taken
- rsp_ready  in  1  response consumer ready
- rsp_z  out  32  result, or 32'h7FC00000 on error
- rsp_tag  out  TAG_W  tag of the command
- rsp_err  out  1  watchdog expired
- hung  out  1  sticky; set on timeout, cleared only by rst
- op_count  out  32  successful completions, wraps at 2^32

## Operation
- States: IDLE, ISSUE, WAIT_Z, RESP.
- IDLE: cmd_ready=1, core_z_ack=1. On cmd handshake, register a/b/tag and go to ISSUE. Any core_z_stb seen in IDLE is acked and discarded. This drains stray results after a timeout or a reset of this block.
- ISSUE: core_a_stb=1, cmd_ready=0, core_z_ack=0.
  - Operand transfer occurs at the edge where core_a_stb && core_a_ack are both high; then go to WAIT_Z.
  - core_a/core_b change only on a cmd handshake. They therefore stay stable for the core's one-cycle-late operand capture.
- WAIT_Z: core_a_stb=0, core_z_ack=1. core_a_ack staying high for one cycle after the transfer is ignored.
  - At the edge with core_z_stb && core_z_ack: rsp_z<=core_z, rsp_err<=0, op_count+1, go to RESP.
- Watchdog: counter cleared on entry to ISSUE and increments in ISSUE and WAIT_Z.
  - When it reaches TIMEOUT-1 without a result handshake, the next edge loads rsp_z=32'h7FC00000, rsp_err=1 and hung=1, and moves to RESP.
  - A result handshake on that same edge takes priority: normal response, no error.
- RESP: rsp_valid=1, core_z_ack=0. On rsp_valid && rsp_ready go to IDLE. A new command is accepted no earlier than the following cycle.
- Single outstanding operation. No pipelining.

## Timing
- Reset values:
  - state=IDLE, cmd_ready=1, core_a_stb=core_b_stb=0, core_z_ack=1, rsp_valid=0, rsp_err=0, hung=0, op_count=0.
  - rsp_z, rsp_tag, core_a and core_b are 0.
- All outputs are registered or decoded from state only. No combinational path from an input to an output.
- Cmd edge N: core_a_stb=1 from N+1. With core_a_ack already high, operand transfer at edge N+1.
- Result edge M: rsp_valid=1 from M+1. core_z_ack=0 from M+1, so a core that holds stb one extra cycle is not double-counted.
- Best case, core-independent overhead: 3 cycles from command accept to rsp_valid, plus the core's compute time.
- rst mid-operation: immediate return to IDLE, and the core is not reset by this block. Its eventual result is drained in IDLE.

## Structure
- Shared package fp_hs_pkg: state enum, FP_QNAN=32'h7FC00000, FP_W=32.
- One sub-module, hs_watchdog: clear/enable/expire counter parameterised by TIMEOUT. Everything else is in a single FSM.

## Test plan
- cmd_a=0x40400000, cmd_b=0x40000000, tag 5, against the multiplier model -> rsp_z=0x40C00000, tag 5, err 0, op_count=1.
- core_a_ack held low for 10 cycles after the command -> core_a_stb held 10 cycles, exactly one operand transfer, operands stable throughout.
- rsp_ready low for 7 cycles -> rsp_valid and rsp_z held; cmd_ready=0 until one cycle after the response handshake.
- TIMEOUT=16, core never raises core_z_stb -> rsp_err=1, rsp_z=0x7FC00000 exactly 16 cycles after entering ISSUE; hung=1 until rst.
- A late core_z_stb arriving in IDLE after that timeout -> acked in 1 cycle, no rsp_valid, op_count unchanged.
- rst pulsed in WAIT_Z, core completes later -> all outputs at reset values the cycle after rst; stray result drained; the next command completes normally.
